// File: rtl/cpu_types_pkg.sv
// Datapath types shared with the single-cycle core: ALU operation and register select.
package cpu_types_pkg;

  typedef logic [4:0] regbits_t;

  typedef enum logic [3:0] {
    ALU_SLL  = 4'd0,
    ALU_SRL  = 4'd1,
    ALU_ADD  = 4'd2,
    ALU_SUB  = 4'd3,
    ALU_AND  = 4'd4,
    ALU_OR   = 4'd5,
    ALU_XOR  = 4'd6,
    ALU_NOR  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } aluop_t;

endpackage

// File: rtl/diaosi_types_pkg.sv
// Control-unit select types, multi-cycle state encoding and MIPS opcode/funct constants.
package diaosi_types_pkg;

  typedef enum logic [1:0] {
    PCSRC_PC4    = 2'd0,
    PCSRC_BRANCH = 2'd1,
    PCSRC_JUMP   = 2'd2,
    PCSRC_JR     = 2'd3
  } PCSrc_t;

  typedef enum logic [1:0] {
    WMUX_ALU = 2'd0,
    WMUX_MEM = 2'd1,
    WMUX_LUI = 2'd2,
    WMUX_PC4 = 2'd3
  } W_mux_t;

  typedef enum logic [1:0] {
    ALUSRC_REG   = 2'd0,
    ALUSRC_IMM   = 2'd1,
    ALUSRC_SHAMT = 2'd2
  } ALUSrc_t;

  typedef enum logic {
    EXT_ZERO = 1'b0,
    EXT_SIGN = 1'b1
  } ExtOP_t;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5,
    ST_ERROR  = 3'd6
  } mc_state_t;

  // CLS_ALU_OVF marks the signed ops whose overflow may stop the core.
  typedef enum logic [3:0] {
    CLS_NOP     = 4'd0,
    CLS_ALU     = 4'd1,
    CLS_ALU_OVF = 4'd2,
    CLS_BEQ     = 4'd3,
    CLS_BNE     = 4'd4,
    CLS_JUMP    = 4'd5,
    CLS_JAL     = 4'd6,
    CLS_JR      = 4'd7,
    CLS_LOAD    = 4'd8,
    CLS_STORE   = 4'd9,
    CLS_HALT    = 4'd10
  } instr_class_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

endpackage

// File: rtl/mc_control_unit_if.sv
// Cache-side bus between the multi-cycle control unit (master) and the cache (slave).
// Handshake: a request (i_ren, d_ren, d_wen) is held high and stable until its hit
// (i_hit, d_hit) is seen; a hit only completes a transfer in a cycle whose request is high.
interface mc_control_unit_if #(
  parameter int WORD_W = 32
);
  logic [WORD_W-1:0] instr;
  logic              i_hit;
  logic              d_hit;
  logic              i_ren;
  logic              d_ren;
  logic              d_wen;

  modport master (
    input  instr, i_hit, d_hit,
    output i_ren, d_ren, d_wen
  );

  modport slave (
    output instr, i_hit, d_hit,
    input  i_ren, d_ren, d_wen
  );
endinterface

// File: rtl/mc_instr_decode.sv
// Combinational IR decode: ALU operation, datapath selects and instruction class.
module mc_instr_decode
  import cpu_types_pkg::*;
  import diaosi_types_pkg::*;
(
  input  logic [5:0]   opcode,
  input  logic [5:0]   funct,
  input  regbits_t     rt,
  input  regbits_t     rd,
  output aluop_t       alu_op,
  output PCSrc_t       pc_src,
  output W_mux_t       w_mux,
  output ALUSrc_t      alu_src,
  output ExtOP_t       ext_op,
  output regbits_t     wsel,
  output instr_class_t cls
);

  always_comb begin
    alu_op  = ALU_ADD;
    pc_src  = PCSRC_PC4;
    w_mux   = WMUX_ALU;
    alu_src = ALUSRC_IMM;
    ext_op  = EXT_SIGN;
    wsel    = rt;
    cls     = CLS_NOP;
    case (opcode)
      OP_RTYPE: begin
        alu_src = ALUSRC_REG;
        wsel    = rd;
        cls     = CLS_ALU;
        case (funct)
          FN_SLL:  begin alu_op = ALU_SLL; alu_src = ALUSRC_SHAMT; end
          FN_SRL:  begin alu_op = ALU_SRL; alu_src = ALUSRC_SHAMT; end
          FN_JR:   begin cls = CLS_JR; pc_src = PCSRC_JR; end
          FN_ADD:  begin alu_op = ALU_ADD; cls = CLS_ALU_OVF; end
          FN_ADDU: alu_op = ALU_ADD;
          FN_SUB:  begin alu_op = ALU_SUB; cls = CLS_ALU_OVF; end
          FN_SUBU: alu_op = ALU_SUB;
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_XOR:  alu_op = ALU_XOR;
          FN_NOR:  alu_op = ALU_NOR;
          FN_SLT:  alu_op = ALU_SLT;
          FN_SLTU: alu_op = ALU_SLTU;
          default: cls = CLS_NOP;
        endcase
      end
      OP_J:     begin cls = CLS_JUMP; pc_src = PCSRC_JUMP; end
      OP_JAL: begin
        cls    = CLS_JAL;
        pc_src = PCSRC_JUMP;
        w_mux  = WMUX_PC4;
        wsel   = 5'd31;
      end
      OP_BEQ:   begin cls = CLS_BEQ; alu_op = ALU_SUB; alu_src = ALUSRC_REG; pc_src = PCSRC_BRANCH; end
      OP_BNE:   begin cls = CLS_BNE; alu_op = ALU_SUB; alu_src = ALUSRC_REG; pc_src = PCSRC_BRANCH; end
      OP_ADDI:  cls = CLS_ALU_OVF;
      OP_ADDIU: cls = CLS_ALU;
      OP_SLTI:  begin cls = CLS_ALU; alu_op = ALU_SLT; end
      OP_SLTIU: begin cls = CLS_ALU; alu_op = ALU_SLTU; end
      OP_ANDI:  begin cls = CLS_ALU; alu_op = ALU_AND; ext_op = EXT_ZERO; end
      OP_ORI:   begin cls = CLS_ALU; alu_op = ALU_OR;  ext_op = EXT_ZERO; end
      OP_XORI:  begin cls = CLS_ALU; alu_op = ALU_XOR; ext_op = EXT_ZERO; end
      OP_LUI:   begin cls = CLS_ALU; w_mux = WMUX_LUI; ext_op = EXT_ZERO; end
      OP_LW:    begin cls = CLS_LOAD; w_mux = WMUX_MEM; end
      OP_SW:    cls = CLS_STORE;
      OP_HALT:  cls = CLS_HALT;
      default:  cls = CLS_NOP;
    endcase
  end

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle MIPS control unit: FETCH/DECODE/EXEC/MEM/WB sequencer with instruction
// register, cache stall handling and a memory-timeout watchdog.
module mc_control_unit
  import cpu_types_pkg::*;
  import diaosi_types_pkg::*;
#(
  parameter int WORD_W      = 32,
  parameter int REG_AW      = 5,
  parameter int MEM_TIMEOUT = 16,
  parameter int HALT_ON_OVF = 1
) (
  input  logic                CLK,
  input  logic                nRST,
  mc_control_unit_if.master   bus,
  input  logic                zero_f,
  input  logic                overflow_f,
  output logic                pc_wen,
  output logic                reg_wen,
  output aluop_t              alu_op,
  output PCSrc_t              PCSrc,
  output W_mux_t              W_mux,
  output ALUSrc_t             ALUSrc,
  output ExtOP_t              ExtOP,
  output logic [REG_AW-1:0]   wsel,
  output logic [REG_AW-1:0]   rsel1,
  output logic [REG_AW-1:0]   rsel2,
  output logic [15:0]         imm16,
  output logic [25:0]         j_addr26,
  output logic [4:0]          shamt,
  output logic [31:0]         lui,
  output logic                halt,
  output logic                mem_err,
  output mc_state_t           state_o
);

  localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

  mc_state_t         state_q, state_d;
  logic [WORD_W-1:0] ir_q, ir_d;
  logic [7:0]        tmo_q, tmo_d;

  instr_class_t cls;
  PCSrc_t       dec_pc_src;
  regbits_t     dec_wsel;

  mc_instr_decode u_decode (
    .opcode  (ir_q[31:26]),
    .funct   (ir_q[5:0]),
    .rt      (ir_q[20:16]),
    .rd      (ir_q[15:11]),
    .alu_op  (alu_op),
    .pc_src  (dec_pc_src),
    .w_mux   (W_mux),
    .alu_src (ALUSrc),
    .ext_op  (ExtOP),
    .wsel    (dec_wsel),
    .cls     (cls)
  );

  assign wsel     = REG_AW'(dec_wsel);
  assign rsel1    = REG_AW'(ir_q[25:21]);
  assign rsel2    = REG_AW'(ir_q[20:16]);
  assign imm16    = ir_q[15:0];
  assign j_addr26 = ir_q[25:0];
  assign shamt    = ir_q[10:6];
  assign lui      = {ir_q[15:0], 16'h0000};
  assign state_o  = state_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= ST_FETCH;
      ir_q    <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      tmo_q   <= tmo_d;
    end
  end

  // The counter idles at zero outside FETCH/MEM, so entering either state starts it clean.
  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    tmo_d     = '0;
    bus.i_ren = 1'b0;
    bus.d_ren = 1'b0;
    bus.d_wen = 1'b0;
    pc_wen    = 1'b0;
    reg_wen   = 1'b0;
    PCSrc     = PCSRC_PC4;
    halt      = 1'b0;
    mem_err   = 1'b0;
    unique case (state_q)
      ST_FETCH: begin
        bus.i_ren = 1'b1;
        if (bus.i_hit) begin
          ir_d    = bus.instr;
          pc_wen  = 1'b1;
          state_d = ST_DECODE;
        end else if (tmo_q == TMO_LAST) begin
          state_d = ST_ERROR;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      ST_DECODE: state_d = (cls == CLS_HALT) ? ST_HALT : ST_EXEC;
      ST_EXEC: begin
        PCSrc   = dec_pc_src;
        state_d = ST_FETCH;
        case (cls)
          CLS_BEQ:             pc_wen = zero_f;
          CLS_BNE:             pc_wen = !zero_f;
          CLS_JUMP, CLS_JR:    pc_wen = 1'b1;
          CLS_JAL:             begin pc_wen = 1'b1; reg_wen = 1'b1; end
          CLS_LOAD, CLS_STORE: state_d = ST_MEM;
          CLS_ALU:             state_d = ST_WB;
          CLS_ALU_OVF:         state_d = (overflow_f && (HALT_ON_OVF != 0)) ? ST_HALT : ST_WB;
          default:             state_d = ST_FETCH;
        endcase
      end
      ST_MEM: begin
        bus.d_ren = (cls == CLS_LOAD);
        bus.d_wen = (cls == CLS_STORE);
        if (bus.d_hit) begin
          state_d = (cls == CLS_LOAD) ? ST_WB : ST_FETCH;
        end else if (tmo_q == TMO_LAST) begin
          state_d = ST_ERROR;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      ST_WB: begin
        reg_wen = 1'b1;
        state_d = ST_FETCH;
      end
      ST_HALT:  halt = 1'b1;
      ST_ERROR: begin
        halt    = 1'b1;
        mem_err = 1'b1;
      end
      default:  state_d = ST_FETCH;
    endcase
  end

endmodule
